dcache_flush_engine: RTL
========================

# dcache_flush_engine

Hardware flush/clean engine for the set-associative data cache. On request it walks every (set, way) entry of the cache SRAM and writes each valid-dirty line back to off-chip data memory over the existing enable/write/ack memory handshake. It then clears the dirty bit, or invalidates the entry in invalidate mode. It sits between the cache SRAM and the memory port, stalls the CPU while busy, and generalises flushing to any number of ways, sets and line widths.

## Interface
Parameters:
- WAYS, 2, associativity (power of two, ≥1)
- SETS, 16, sets per way (power of two)
- LINE_W, 256, line width in bits
- TAG_W, 23, stored tag width, excluding valid/dirty
- OFF_W, 5, byte-offset bits per line
- ADDR_W, 32, memory address width; must equal TAG_W+log2(SETS)+OFF_W

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-low
- flush_req_i  in  1  start request, sampled only in IDLE
- mode_inv_i  in  1  1 = flush+invalidate, 0 = clean only; latched at start
- flush_busy_o  out  1  high from the first SCAN cycle through the DONE cycle
- flush_done_o  out  1  one-cycle pulse in DONE
- cpu_stall_o  out  1  equal to flush_busy_o
- sram_idx_o  out  log2(SETS)  set index being accessed
- sram_way_o  out  max(1,log2(WAYS))  way being accessed
- sram_valid_i, sram_dirty_i  in  1  entry status at idx/way; combinational read, same cycle
- sram_tag_i  in  TAG_W  entry tag
- sram_data_i  in  LINE_W  entry data
- sram_wr_o  out  1  one-cycle status update strobe
- sram_valid_o, sram_dirty_o  out  1  new status written with sram_wr_o
- mem_enable_o, mem_write_o  out  1  memory request
- mem_addr_o  out  ADDR_W  {tag, idx, OFF_W'b0}
- mem_data_o  out  LINE_W  latched line data
- mem_ack_i  in  1  memory completion
- wb_count_o  out  log2(WAYS*SETS)+1  number of lines written back by the last flush

## Operation
- States: IDLE, SCAN, REQ, UPD, DONE.
- **IDLE:** if flush_req_i=1, latch mode_inv_i, clear the idx/way pointer and wb_count_o, then go to SCAN. All other inputs are ignored.
- **SCAN:** drive idx/way.
  - valid&dirty: latch tag/data into mem_addr_o/mem_data_o, go to REQ.
  - valid&!dirty&inv: go to UPD.
  - otherwise: advance.
- **REQ:** hold mem_enable_o=mem_write_o=1 with stable addr/data until mem_ack_i=1. In the ack cycle, increment wb_count_o and go to UPD. mem_enable_o deasserts the cycle after the ack.
- **UPD:** sram_wr_o=1 for one cycle, with sram_dirty_o=0 and sram_valid_o=!inv. Then advance.
- **Advance:** way increments first, then idx. After the last entry (idx=SETS-1, way=WAYS-1), go to DONE; otherwise go to SCAN.
- **DONE:** flush_done_o=1, then go to IDLE.
- Boundaries:
  - flush_req_i while busy or in DONE: ignored.
  - flush_req_i held high: a new flush starts in the IDLE cycle after DONE.
  - mem_ack_i outside REQ: ignored.
  - Lines that are not valid are never written to memory, even if dirty.
  - The wb_count_o counter does not wrap: its maximum is WAYS*SETS.

## Timing
- Reset (rst_i=0 at a clock edge) forces IDLE on that edge. All outputs read 0: the flags, sram_idx_o, sram_way_o, mem_addr_o, mem_data_o and wb_count_o.
- Reset in REQ abandons the write. mem_enable_o is 0 the next cycle and the SRAM entry keeps its dirty bit.
- Per entry cost:
  - clean entry: 1 cycle
  - clean entry being invalidated: 2 cycles
  - dirty entry: 1 + L + 1 cycles, where L is the ack latency counted in cycles from the first REQ cycle up to and including the ack cycle
- Empty cache: flush_busy_o is high for WAYS*SETS+1 cycles, including DONE.
- flush_done_o rises the cycle after the last entry is processed.

## Configuration
- DCACHE_FLUSH_CNT_EN: when defined, the wb_count_o counter is implemented.
- When it is not defined, wb_count_o is tied to 0 and no counter flops are present.
- All other behaviour is identical with or without the macro.

## Test plan
All scenarios use default parameters and a memory model with a 10-cycle ack.
- **Empty cache:** all entries invalid; pulse flush_req_i.
  - busy for 33 cycles; done pulses once.
  - mem_enable_o never asserts; wb_count_o=0.
- **Clean mode, one dirty line:** set 3 way 1 valid+dirty, tag 0x000001, data 256'hA5…A5; mode_inv=0.
  - exactly one write to addr 0x00000260 with data A5…A5.
  - entry ends valid=1, dirty=0; wb_count_o=1.
- **Invalidate mode:** the same dirty line plus set 0 way 0 valid-clean; mode_inv=1.
  - one memory write.
  - both entries end valid=0; wb_count_o=1.
- **Reset during REQ:** drive rst_i=0 on the 5th REQ cycle.
  - next cycle mem_enable_o=0 and flush_busy_o=0.
  - set 3 way 1 is still dirty.
- **Held request:** hold flush_req_i high through two flushes.
  - the second flush starts one IDLE cycle after DONE and performs no memory writes.
  - wb_count_o=0 after the second flush.
- **Spurious ack:** pulse mem_ack_i during SCAN of an empty cache.
  - no state change and no count increment.

Source files
------------

// File: rtl/dcache_flush_engine.sv
// -----------------------------------------------------------------------------
// dcache_flush_engine
//
// Walks every (set, way) entry of the data-cache SRAM once per request. Each
// valid+dirty line is written back to memory over the enable/write/ack
// handshake, and its status is then updated: the dirty bit is cleared, and in
// invalidate mode the valid bit is cleared as well. Valid clean lines are only
// touched in invalidate mode. Lines that are not valid are skipped, even when
// their dirty bit is set. The CPU is stalled for the whole walk.
//
// Optional build macro:
//   DCACHE_FLUSH_CNT_EN  implements the write-back counter behind wb_count_o.
//                        Without it, wb_count_o is tied to zero and the
//                        counter flops are absent.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active low
//   flush_req_i    start request, sampled only in IDLE
//   mode_inv_i     1 = flush+invalidate, 0 = clean only (latched at start)
//   flush_busy_o   high from the first SCAN cycle through the DONE cycle
//   flush_done_o   one-cycle pulse in DONE
//   cpu_stall_o    copy of flush_busy_o
//   sram_idx_o     set index being accessed
//   sram_way_o     way being accessed
//   sram_valid_i   entry valid bit (combinational read, same cycle)
//   sram_dirty_i   entry dirty bit
//   sram_tag_i     entry tag
//   sram_data_i    entry line data
//   sram_wr_o      one-cycle status write strobe
//   sram_valid_o   new valid bit, written with sram_wr_o
//   sram_dirty_o   new dirty bit, written with sram_wr_o
//   mem_enable_o   memory request enable
//   mem_write_o    memory request is a write
//   mem_addr_o     {tag, idx, zero offset} of the line being written back
//   mem_data_o     line data being written back
//   mem_ack_i      memory completion
//   wb_count_o     number of lines written back by the last flush
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for flush_req_i
//   SCAN  | examining the entry at the current idx/way
//   REQ   | write-back in flight, waiting for mem_ack_i
//   UPD   | writing the new valid/dirty status into the SRAM
//   DONE  | walk finished, flush_done_o pulses
// -----------------------------------------------------------------------------
module dcache_flush_engine #(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 23,
  parameter int OFF_W  = 5,
  parameter int ADDR_W = 32
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_req_i,
  input  logic                                        mode_inv_i,
  output logic                                        flush_busy_o,
  output logic                                        flush_done_o,
  output logic                                        cpu_stall_o,
  output logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0]  sram_idx_o,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]  sram_way_o,
  input  logic                                        sram_valid_i,
  input  logic                                        sram_dirty_i,
  input  logic [TAG_W-1:0]                            sram_tag_i,
  input  logic [LINE_W-1:0]                           sram_data_i,
  output logic                                        sram_wr_o,
  output logic                                        sram_valid_o,
  output logic                                        sram_dirty_o,
  output logic                                        mem_enable_o,
  output logic                                        mem_write_o,
  output logic [ADDR_W-1:0]                           mem_addr_o,
  output logic [LINE_W-1:0]                           mem_data_o,
  input  logic                                        mem_ack_i,
  output logic [$clog2(WAYS*SETS):0]                  wb_count_o
);

  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_REQ  = 3'd2,
    ST_UPD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]  idx_q;
  logic [WAY_W-1:0]  way_q;
  logic              inv_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;

  logic hit_dirty;
  logic hit_clean_inv;
  logic last_entry;
  logic advance;
  logic start;

  // Invalid lines are never written back, whatever their dirty bit says.
  assign hit_dirty     = sram_valid_i & sram_dirty_i;
  assign hit_clean_inv = sram_valid_i & ~sram_dirty_i & inv_q;
  assign last_entry    = (idx_q == IDX_W'(SETS - 1)) && (way_q == WAY_W'(WAYS - 1));
  assign start         = (state_q == ST_IDLE) && flush_req_i;

  // The pointer moves on when an entry needs nothing in SCAN, or after its
  // status update has been written.
  assign advance = ((state_q == ST_SCAN) && !hit_dirty && !hit_clean_inv) ||
                   (state_q == ST_UPD);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req_i) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit_dirty) begin
          state_d = ST_REQ;
        end else if (hit_clean_inv) begin
          state_d = ST_UPD;
        end else if (last_entry) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_REQ: begin
        if (mem_ack_i) begin
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        state_d = last_entry ? ST_DONE : ST_SCAN;
      end
      ST_DONE: begin
        // A request still high here is picked up by the following IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_busy_o = 1'b0;
    flush_done_o = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    sram_wr_o    = 1'b0;
    sram_valid_o = 1'b0;
    sram_dirty_o = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        flush_busy_o = 1'b1;
      end
      ST_REQ: begin
        flush_busy_o = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
      end
      ST_UPD: begin
        flush_busy_o = 1'b1;
        sram_wr_o    = 1'b1;
        sram_valid_o = ~inv_q;
        sram_dirty_o = 1'b0;
      end
      ST_DONE: begin
        flush_busy_o = 1'b1;
        flush_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cpu_stall_o = flush_busy_o;
  assign sram_idx_o  = idx_q;
  assign sram_way_o  = way_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;

  // ---------------------------------------------------------------------------
  // Walk pointer, latched mode and write-back address/data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      idx_q  <= '0;
      way_q  <= '0;
      inv_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (start) begin
        inv_q <= mode_inv_i;
        idx_q <= '0;
        way_q <= '0;
      end

      // Address and data are captured once and held steady for the whole
      // request, independent of what the SRAM read port shows meanwhile.
      if ((state_q == ST_SCAN) && hit_dirty) begin
        addr_q <= {sram_tag_i, idx_q, {OFF_W{1'b0}}};
        data_q <= sram_data_i;
      end

      // Way is the fast-moving index; the set advances when the way wraps.
      if (advance) begin
        if (way_q == WAY_W'(WAYS - 1)) begin
          way_q <= '0;
          idx_q <= idx_q + 1'b1;
        end else begin
          way_q <= way_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back counter
  // ---------------------------------------------------------------------------
`ifdef DCACHE_FLUSH_CNT_EN
  localparam int CNT_W   = $clog2(WAYS * SETS) + 1;
  localparam int ENTRIES = WAYS * SETS;

  logic [CNT_W-1:0] wb_cnt_q;

  // Saturates at the entry count so it can never wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb_cnt_q <= '0;
    end else if (start) begin
      wb_cnt_q <= '0;
    end else if ((state_q == ST_REQ) && mem_ack_i &&
                 (wb_cnt_q != CNT_W'(ENTRIES))) begin
      wb_cnt_q <= wb_cnt_q + 1'b1;
    end
  end

  assign wb_count_o = wb_cnt_q;
`else
  assign wb_count_o = '0;
`endif

endmodule
